regfile_wb_arb: RTL and testbench

REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

---
 rtl/regfile_wb_arb.sv | 156 +++++++++++++++
 tb/tb_regfile_wb_arb.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb.sv
// Register-file writeback arbiter: one ALU holding register plus an LSU FIFO,
// with a starvation guard and a registered write port. Optional macro WB_FWD_EN adds forwarding read ports.
module regfile_wb_arb #(
   parameter int XLEN      = 32,
   parameter int LSU_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pend_mask
`ifdef WB_FWD_EN
   ,
   input  logic [4:0]      fwd_raddr1,
   input  logic [4:0]      fwd_raddr2,
   output logic            fwd_hit1,
   output logic            fwd_hit2,
   output logic [XLEN-1:0] fwd_data1,
   output logic [XLEN-1:0] fwd_data2
`endif
);

   localparam int PW = $clog2(LSU_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(LSU_DEPTH);

   logic            r_alu_vld;
   logic [4:0]      r_alu_rd;
   logic [XLEN-1:0] r_alu_data;
   logic [4:0]      r_lsu_rd   [LSU_DEPTH];
   logic [XLEN-1:0] r_lsu_data [LSU_DEPTH];
   logic [PW-1:0]   r_wptr, r_rptr;
   logic [CW-1:0]   r_count;

   logic            w_lsu_nempty, w_grant_lsu, w_grant_alu, w_grant;
   logic            w_push, w_pop, w_alu_accept;
   logic [4:0]      w_grant_rd;
   logic [XLEN-1:0] w_grant_data;

   // LSU head wins only when the ALU slot is empty or the FIFO is full (starvation guard).
   assign w_lsu_nempty = (r_count != '0);
   assign w_grant_lsu  = w_lsu_nempty && (!r_alu_vld || (r_count == FULL));
   assign w_grant_alu  = r_alu_vld && !w_grant_lsu;
   assign w_grant      = w_grant_lsu || w_grant_alu;
   assign w_grant_rd   = w_grant_lsu ? r_lsu_rd[r_rptr]   : r_alu_rd;
   assign w_grant_data = w_grant_lsu ? r_lsu_data[r_rptr] : r_alu_data;

   assign alu_ready    = !r_alu_vld || w_grant_alu;
   assign lsu_ready    = (r_count != FULL);
   assign w_alu_accept = alu_valid && alu_ready;
   assign w_push       = lsu_valid && lsu_ready;
   assign w_pop        = w_grant_lsu;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_alu_vld  <= 1'b0;
         r_alu_rd   <= '0;
         r_alu_data <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         if (w_alu_accept) begin
            r_alu_vld  <= 1'b1;
            r_alu_rd   <= alu_rd;
            r_alu_data <= alu_data;
         end else if (w_grant_alu) begin
            r_alu_vld  <= 1'b0;
         end
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         rf_we <= w_grant && (w_grant_rd != 5'd0);
         if (w_grant) begin
            rf_waddr <= w_grant_rd;
            rf_wdata <= w_grant_data;
         end
      end
   end

   // NOTE: FIFO storage is not reset; occupancy is tracked solely by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_lsu_rd[r_wptr]   <= lsu_rd;
         r_lsu_data[r_wptr] <= lsu_data;
      end
   end

   // NOTE: every always_comb output is given a default first so no latch is inferred.
   always_comb begin
      logic [PW-1:0] w_idx;
      pend_mask = '0;
      w_idx     = '0;
      if (r_alu_vld) pend_mask[r_alu_rd] = 1'b1;
      for (int k = 0; k < LSU_DEPTH; k++) begin
         w_idx = r_rptr + PW'(k);
         if (CW'(k) < r_count) pend_mask[r_lsu_rd[w_idx]] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

`ifdef WB_FWD_EN
   logic [4:0]      w_fwd_raddr [2];
   logic            w_fwd_hit   [2];
   logic [XLEN-1:0] w_fwd_data  [2];

   assign w_fwd_raddr[0] = fwd_raddr1;
   assign w_fwd_raddr[1] = fwd_raddr2;

   // Scan oldest to youngest so later matches override; the ALU slot is youngest of all.
   always_comb begin
      logic [PW-1:0] w_fidx;
      w_fidx = '0;
      for (int p = 0; p < 2; p++) begin
         w_fwd_hit[p]  = 1'b0;
         w_fwd_data[p] = '0;
         if (w_fwd_raddr[p] != 5'd0) begin
            for (int k = 0; k < LSU_DEPTH; k++) begin
               w_fidx = r_rptr + PW'(k);
               if ((CW'(k) < r_count) && (r_lsu_rd[w_fidx] == w_fwd_raddr[p])) begin
                  w_fwd_hit[p]  = 1'b1;
                  w_fwd_data[p] = r_lsu_data[w_fidx];
               end
            end
            if (r_alu_vld && (r_alu_rd == w_fwd_raddr[p])) begin
               w_fwd_hit[p]  = 1'b1;
               w_fwd_data[p] = r_alu_data;
            end
         end
      end
   end

   assign fwd_hit1  = w_fwd_hit[0];
   assign fwd_hit2  = w_fwd_hit[1];
   assign fwd_data1 = w_fwd_data[0];
   assign fwd_data2 = w_fwd_data[1];
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed bench for regfile_wb_arb; forwarding checks compile in when WB_FWD_EN is defined.
module tb_regfile_wb_arb;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid, lsu_valid;
   logic            alu_ready, lsu_ready;
   logic [4:0]      alu_rd, lsu_rd;
   logic [XLEN-1:0] alu_data, lsu_data;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     pend_mask;
`ifdef WB_FWD_EN
   logic [4:0]      fwd_raddr1, fwd_raddr2;
   logic            fwd_hit1, fwd_hit2;
   logic [XLEN-1:0] fwd_data1, fwd_data2;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   regfile_wb_arb #(.XLEN(XLEN), .LSU_DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_ready (alu_ready),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pend_mask (pend_mask)
`ifdef WB_FWD_EN
      ,
      .fwd_raddr1(fwd_raddr1),
      .fwd_raddr2(fwd_raddr2),
      .fwd_hit1  (fwd_hit1),
      .fwd_hit2  (fwd_hit2),
      .fwd_data1 (fwd_data1),
      .fwd_data2 (fwd_data2)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one posedge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
   endtask

   function automatic logic [XLEN-1:0] dval(input logic [4:0] rd);
      return 32'hC0DE_0000 | {27'd0, rd};
   endfunction

   // Starvation scenario: per cycle ALU rd / LSU rd (0 = idle), readies, then rf after the edge.
   typedef struct {
      logic [4:0] a_rd;
      logic [4:0] l_rd;
      logic       exp_ar;
      logic       exp_lr;
      logic       exp_we;
      logic [4:0] exp_addr;
   } starve_row_t;

   starve_row_t starve_tbl [12];

   initial begin
      starve_tbl[0]  = '{5'd10, 5'd20, 1'b1, 1'b1, 1'b0, 5'd0};
      starve_tbl[1]  = '{5'd11, 5'd21, 1'b1, 1'b1, 1'b1, 5'd10};
      starve_tbl[2]  = '{5'd12, 5'd22, 1'b1, 1'b1, 1'b1, 5'd11};
      starve_tbl[3]  = '{5'd13, 5'd23, 1'b1, 1'b1, 1'b1, 5'd12};
      starve_tbl[4]  = '{5'd14, 5'd24, 1'b0, 1'b0, 1'b1, 5'd20};
      starve_tbl[5]  = '{5'd14, 5'd24, 1'b1, 1'b1, 1'b1, 5'd13};
      starve_tbl[6]  = '{5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd21};
      starve_tbl[7]  = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd14};
      starve_tbl[8]  = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd22};
      starve_tbl[9]  = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd23};
      starve_tbl[10] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd24};
      starve_tbl[11] = '{5'd0,  5'd0,  1'b1, 1'b1, 1'b0, 5'd0};
   end

   initial begin
      rst = 1'b0;
      idle_inputs();
`ifdef WB_FWD_EN
      fwd_raddr1 = '0;
      fwd_raddr2 = '0;
`endif
      #2;
      check("rst_rf_we",     rf_we,     0);
      check("rst_rf_waddr",  rf_waddr,  0);
      check("rst_rf_wdata",  rf_wdata,  0);
      check("rst_alu_ready", alu_ready, 1);
      check("rst_lsu_ready", lsu_ready, 1);
      check("rst_pend_mask", pend_mask, 0);
      tick();
      tick();
      rst = 1'b1;

      // Single ALU write: pending for one cycle, written two posedges later.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
      check("alu1_ready", alu_ready, 1);
      tick();
      idle_inputs();
      check("alu1_pend",   pend_mask, 32'h1 << 5);
      check("alu1_we_lat", rf_we,     0);
      tick();
      check("alu1_we",    rf_we,     1);
      check("alu1_addr",  rf_waddr,  5);
      check("alu1_data",  rf_wdata,  32'h11);
      check("alu1_pend0", pend_mask, 0);
      tick();
      check("alu1_we_off",   rf_we,    0);
      check("alu1_addr_hld", rf_waddr, 5);
      check("alu1_data_hld", rf_wdata, 32'h11);

      // LSU stream with ALU idle: no fall-through, then in-order drain one per cycle.
      for (int k = 1; k <= 4; k++) begin
         lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = dval(5'(k));
         check("lsu_ready", lsu_ready, 1);
         tick();
         if (k == 1) begin
            check("lsu_nofall_we", rf_we, 0);
            check("lsu_pend1",     pend_mask, 32'h2);
         end else begin
            check("lsu_we",   rf_we,    1);
            check("lsu_addr", rf_waddr, 5'(k - 1));
            check("lsu_data", rf_wdata, dval(5'(k - 1)));
         end
      end
      idle_inputs();
      tick();
      check("lsu_we4",   rf_we,    1);
      check("lsu_addr4", rf_waddr, 4);
      tick();
      check("lsu_drained_we", rf_we, 0);

      // ALU continuously busy while LSU fills: starvation guard grants LSU at full.
      for (int c = 0; c < 12; c++) begin
         alu_valid = (starve_tbl[c].a_rd != 5'd0);
         alu_rd    = starve_tbl[c].a_rd;
         alu_data  = dval(starve_tbl[c].a_rd);
         lsu_valid = (starve_tbl[c].l_rd != 5'd0);
         lsu_rd    = starve_tbl[c].l_rd;
         lsu_data  = dval(starve_tbl[c].l_rd);
         check($sformatf("stv_ar_c%0d", c), alu_ready, starve_tbl[c].exp_ar);
         check($sformatf("stv_lr_c%0d", c), lsu_ready, starve_tbl[c].exp_lr);
         if (c == 4)
            check("stv_pend_c4", pend_mask,
                  (32'h1 << 13) | (32'h1 << 20) | (32'h1 << 21) | (32'h1 << 22) | (32'h1 << 23));
         tick();
         check($sformatf("stv_we_c%0d", c), rf_we, starve_tbl[c].exp_we);
         if (starve_tbl[c].exp_we) begin
            check($sformatf("stv_addr_c%0d", c), rf_waddr, starve_tbl[c].exp_addr);
            check($sformatf("stv_data_c%0d", c), rf_wdata, dval(starve_tbl[c].exp_addr));
         end
      end
      idle_inputs();

      // rd == 0 is accepted but never writes.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFF;
      check("rd0_ready", alu_ready, 1);
      tick();
      idle_inputs();
      check("rd0_pend", pend_mask, 0);
      check("rd0_we_a", rf_we,     0);
      tick();
      check("rd0_we_b",   rf_we,     0);
      check("rd0_ready2", alu_ready, 1);

      // Queue three LSU entries behind a busy ALU, then reset mid-cycle.
      for (int c = 0; c < 3; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(c + 1);  alu_data = dval(5'(c + 1));
         lsu_valid = 1'b1; lsu_rd = 5'(c + 16); lsu_data = dval(5'(c + 16));
         tick();
      end
      idle_inputs();
      check("pre_rst_we",   rf_we,     1);
      check("pre_rst_pend", pend_mask, (32'h1 << 3) | (32'h7 << 16));
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_we",    rf_we,     0);
      check("mid_rst_pend",  pend_mask, 0);
      check("mid_rst_ar",    alu_ready, 1);
      check("mid_rst_lr",    lsu_ready, 1);
      check("mid_rst_waddr", rf_waddr,  0);
      tick();
      rst = 1'b1;

      // First request after release is accepted on the first posedge.
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      idle_inputs();
      check("post_rst_pend", pend_mask, 32'h1 << 9);
      check("post_rst_we0",  rf_we,     0);
      tick();
      check("post_rst_we",   rf_we,    1);
      check("post_rst_addr", rf_waddr, 9);
      for (int c = 0; c < 4; c++) begin
         tick();
         check($sformatf("post_rst_quiet%0d", c), rf_we, 0);
      end

`ifdef WB_FWD_EN
      // Two LSU writes to rd 7 queued behind the ALU; youngest wins.
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hA;
      tick();
      alu_rd = 5'd4; alu_data = 32'h44;
      lsu_data = 32'hB;
      tick();
      idle_inputs();
      fwd_raddr1 = 5'd7;
      fwd_raddr2 = 5'd0;
      #1;
      check("fwd_hit1",  fwd_hit1,  1);
      check("fwd_data1", fwd_data1, 32'hB);
      check("fwd_hit2",  fwd_hit2,  0);
      fwd_raddr2 = 5'd4;
      #1;
      check("fwd_alu_hit",  fwd_hit2,  1);
      check("fwd_alu_data", fwd_data2, 32'h44);
      fwd_raddr1 = 5'd0;
      fwd_raddr2 = 5'd0;
      for (int c = 0; c < 4; c++) tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
